keccak_driver: RTL and testbench
================================

KECCAK_DRIVER -- requirements
Module: keccak_driver

Interface
REQ-001 Parameter: none; word width w and mode encodings come from keccak_pkg (w = 64).
REQ-002 clk  in  1  single clock; all state rising-edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cmd_valid / cmd_ready  in / out  1 / 1  job request handshake.
REQ-005 cmd_mode  in  2  operation mode, keccak_pkg encoding.
REQ-006 cmd_in_len  in  32  message length in bytes.
REQ-007 cmd_out_len  in  32  requested output length in bits.
REQ-008 msg_valid / msg_ready / msg_data  in / out / in  1 / 1 / w  message word source.
REQ-009 core_valid_n  out  1  drives core valid_in; active-low.
REQ-010 core_ready  in  1  core ready_out; active-high.
REQ-011 core_data  out  w  drives core data_in.
REQ-012 core_valid_out  in  1  core valid_out; active-high.
REQ-013 core_ready_n  out  1  drives core ready_in; active-low.
REQ-014 core_data_out  in  w  core data_out.
REQ-015 res_valid / res_ready / res_data / res_last  out / in / out / out  1 / 1 / w / 1  digest word sink.
REQ-016 busy  out  1  job in progress; done  out  1  one-cycle pulse at job end.

Function
REQ-017 FSM states IDLE, HDR, MSG, DRAIN, DONE.
REQ-018 IDLE: cmd_ready=1; on cmd_valid, latch mode, in_words = ceil(cmd_in_len/8), out_words = ceil(cmd_out_len/64); next HDR.
REQ-019 Header word: [63:62] mode, [61:32] cmd_in_len[29:0], [31:0] cmd_out_len.
REQ-020 Core input transfer occurs on a cycle with core_valid_n=0 and core_ready=1.
REQ-021 HDR: core_valid_n=0, core_data=header; on transfer go to MSG, or to DRAIN when in_words=0.
REQ-022 MSG: core_valid_n = !msg_valid, core_data = msg_data, msg_ready = core_ready; msg_ready is 0 in every other state.
REQ-023 MSG: each transfer increments a 30-bit input counter; the transfer of word in_words-1 moves the FSM to DRAIN, or to DONE when out_words=0.
REQ-024 DRAIN: core_ready_n = !res_ready, res_valid = core_valid_out, res_data = core_data_out; core_ready_n is 1 in every other state.
REQ-025 A DRAIN transfer occurs when core_valid_out=1 and res_ready=1; each transfer increments a 30-bit output counter.
REQ-026 res_last = 1 on the word whose index is out_words-1; that transfer moves the FSM to DONE.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; the next cmd is accepted no earlier than the following cycle.
REQ-028 busy=1 in HDR, MSG, DRAIN and DONE.
REQ-029 core_valid_out outside DRAIN is ignored; the core is not acknowledged and no word is forwarded.
REQ-030 All core-facing and sink outputs are combinational from state plus handshake inputs; latency msg->core and core->res is 0 cycles.
REQ-031 No timeout: stalls on msg_valid, core_ready, core_valid_out or res_ready hold state indefinitely.

Reset
REQ-032 While rst=1: state=IDLE, counters=0, latched command=0.
REQ-033 Outputs during reset: cmd_ready=1, msg_ready=0, core_valid_n=1, core_ready_n=1, res_valid=0, res_last=0, busy=0, done=0.
REQ-034 Reset mid-job aborts the job immediately with no drain; the core must be reset in the same cycle.

Structure
REQ-035 keccak_pkg gains driver_state_t, the header field positions, and the byte-to-word and bit-to-word ceiling functions.
REQ-036 One sub-module, word_counter (30-bit, load/increment/terminal-count flag), is instantiated twice (input and output).

Verification
REQ-037 Mode SHAKE128, in_len=0, out_len=256 -> header word only, no msg_ready, 4 res words, res_last on the 4th, done pulse.
REQ-038 in_len=17, out_len=64 -> 3 msg words forwarded in order, 1 res word with res_last=1.
REQ-039 Random msg_valid/core_ready gaps, in_len=200 -> exactly 25 core transfers after the header; no word dropped or duplicated.
REQ-040 res_ready held at 0 for 10 cycles in DRAIN -> core_ready_n=1 and res_data stable until res_ready=1.
REQ-041 rst asserted mid-MSG at word 5 of 10 -> the next cycle shows all REQ-033 values; a new cmd is accepted after rst is released.
REQ-042 out_len=1 -> out_words=1; out_len=65 -> out_words=2, res_last on word 2.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak core driver.
// Contents: word width, counter width, mode encoding, driver FSM states,
// header field positions, and length-to-word ceiling helpers.
package keccak_pkg;

    localparam int unsigned W    = 64;  // core data word width
    localparam int unsigned CntW = 30;  // input/output word counter width

    typedef enum logic [1:0] {
        ModeSha256   = 2'd0,
        ModeSha512   = 2'd1,
        ModeShake128 = 2'd2,
        ModeShake256 = 2'd3
    } keccak_mode_t;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StHdr   = 3'd1,
        StMsg   = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } driver_state_t;

    // Header word layout: [63:62] mode, [61:32] in_len[29:0], [31:0] out_len
    localparam int unsigned HdrModeLsb   = 62;
    localparam int unsigned HdrInLenLsb  = 32;
    localparam int unsigned HdrOutLenLsb = 0;

    // ceil(len_bytes / 8); widened by one bit so the +7 cannot wrap
    function automatic logic [CntW-1:0] bytes_to_words(input logic [31:0] len_bytes);
        logic [32:0] t;
        t = {1'b0, len_bytes} + 33'd7;
        return t[32:3];
    endfunction

    // ceil(len_bits / 64)
    function automatic logic [CntW-1:0] bits_to_words(input logic [31:0] len_bits);
        logic [32:0] t;
        t = {1'b0, len_bits} + 33'd63;
        return {3'b000, t[32:6]};
    endfunction

endpackage

// File: rtl/keccak_driver_word_counter.sv
// word_counter: 30-bit word counter with synchronous load, increment, and a
// terminal-count flag that is high while the count equals i_term.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_load         load i_load_val (has priority over i_inc)
//   i_load_val     value to load
//   i_inc          increment by one
//   i_term         terminal value compared against the count
//   o_tc           count == i_term
module word_counter
    import keccak_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic [CntW-1:0] i_load_val,
    input  logic            i_inc,
    input  logic [CntW-1:0] i_term,
    output logic            o_tc
);

    logic [CntW-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= r_count + {{(CntW-1){1'b0}}, 1'b1};
        end
    end

    assign o_tc = (r_count == i_term);

endmodule

// File: rtl/keccak_driver.sv
// keccak_driver: sequences one hashing job into a Keccak core.
// Sends a header word, forwards the message words, then drains the digest
// words from the core into the result sink. All core/sink outputs are
// combinational from state and handshake inputs (zero-cycle pass-through).
// Ports:
//   i_clk, i_rst                         clock, asynchronous active-high reset
//   i_cmd_*/o_cmd_ready                  job request (mode, byte length, bit length)
//   i_msg_valid/o_msg_ready/i_msg_data   message word source
//   o_core_valid_n/i_core_ready/o_core_data        core input (valid active-low)
//   i_core_valid_out/o_core_ready_n/i_core_data_out core output (ready active-low)
//   o_res_valid/i_res_ready/o_res_data/o_res_last  digest word sink
//   o_busy, o_done                       job in progress, end-of-job pulse
module keccak_driver
    import keccak_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [1:0]    i_cmd_mode,
    input  logic [31:0]   i_cmd_in_len,
    input  logic [31:0]   i_cmd_out_len,
    input  logic          i_msg_valid,
    output logic          o_msg_ready,
    input  logic [W-1:0]  i_msg_data,
    output logic          o_core_valid_n,
    input  logic          i_core_ready,
    output logic [W-1:0]  o_core_data,
    input  logic          i_core_valid_out,
    output logic          o_core_ready_n,
    input  logic [W-1:0]  i_core_data_out,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [W-1:0]  o_res_data,
    output logic          o_res_last,
    output logic          o_busy,
    output logic          o_done
);

    driver_state_t   r_state, w_state_next;

    logic [1:0]      r_mode;
    logic [29:0]     r_in_len;
    logic [31:0]     r_out_len;
    logic [CntW-1:0] r_in_words;
    logic [CntW-1:0] r_out_words;

    logic            w_load;
    logic            w_in_inc;
    logic            w_out_inc;
    logic            w_in_tc;
    logic            w_out_tc;
    logic [W-1:0]    w_header;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mode      <= '0;
            r_in_len    <= '0;
            r_out_len   <= '0;
            r_in_words  <= '0;
            r_out_words <= '0;
        end else if (w_load) begin
            r_mode      <= i_cmd_mode;
            r_in_len    <= i_cmd_in_len[29:0];
            r_out_len   <= i_cmd_out_len;
            r_in_words  <= bytes_to_words(i_cmd_in_len);
            r_out_words <= bits_to_words(i_cmd_out_len);
        end
    end

    assign w_header = {r_mode, r_in_len, r_out_len};

    // Terminal value is the index of the last word; both counters restart
    // from zero whenever a new command is accepted.
    word_counter u_in_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val ('0),
        .i_inc      (w_in_inc),
        .i_term     (r_in_words - 30'd1),
        .o_tc       (w_in_tc)
    );

    word_counter u_out_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val ('0),
        .i_inc      (w_out_inc),
        .i_term     (r_out_words - 30'd1),
        .o_tc       (w_out_tc)
    );

    always_comb begin
        w_state_next   = r_state;
        w_load         = 1'b0;
        w_in_inc       = 1'b0;
        w_out_inc      = 1'b0;
        o_cmd_ready    = 1'b0;
        o_msg_ready    = 1'b0;
        o_core_valid_n = 1'b1;
        o_core_data    = '0;
        o_core_ready_n = 1'b1;
        o_res_valid    = 1'b0;
        o_res_data     = '0;
        o_res_last     = 1'b0;
        o_done         = 1'b0;

        unique case (r_state)
            StIdle: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    w_load       = 1'b1;
                    w_state_next = StHdr;
                end
            end
            StHdr: begin
                o_core_valid_n = 1'b0;
                o_core_data    = w_header;
                if (i_core_ready) begin
                    if (r_in_words != '0) begin
                        w_state_next = StMsg;
                    end else if (r_out_words != '0) begin
                        w_state_next = StDrain;
                    end else begin
                        // nothing to send or drain: an empty drain would never end
                        w_state_next = StDone;
                    end
                end
            end
            StMsg: begin
                o_core_valid_n = ~i_msg_valid;
                o_core_data    = i_msg_data;
                o_msg_ready    = i_core_ready;
                if (i_msg_valid && i_core_ready) begin
                    w_in_inc = 1'b1;
                    if (w_in_tc) begin
                        w_state_next = (r_out_words == '0) ? StDone : StDrain;
                    end
                end
            end
            StDrain: begin
                o_core_ready_n = ~i_res_ready;
                o_res_valid    = i_core_valid_out;
                o_res_data     = i_core_data_out;
                o_res_last     = i_core_valid_out & w_out_tc;
                if (i_core_valid_out && i_res_ready) begin
                    w_out_inc = 1'b1;
                    if (w_out_tc) begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_busy = (r_state != StIdle);

endmodule

// File: tb/tb_keccak_driver.sv
// Self-checking bench for keccak_driver. A fake message source and fake core
// are driven from queues; a monitor checks every core input transfer and
// every result transfer against expected queues filled when a job is issued.
module tb_keccak_driver;
    import keccak_pkg::*;

    typedef struct packed {
        logic        last;
        logic [63:0] d;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_mode = '0;
    logic [31:0] cmd_in_len = '0, cmd_out_len = '0;
    logic        msg_valid = 1'b0, msg_ready;
    logic [63:0] msg_data = '0;
    logic        core_valid_n, core_ready = 1'b0;
    logic [63:0] core_data;
    logic        core_valid_out = 1'b0, core_ready_n;
    logic [63:0] core_data_out = '0;
    logic        res_valid, res_ready = 1'b0, res_last;
    logic [63:0] res_data;
    logic        busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] msg_src[$];
    logic [63:0] exp_core[$];
    logic [63:0] core_out[$];
    res_t        exp_res[$];

    int done_cnt   = 0;
    int core_xfers = 0;
    int res_xfers  = 0;
    int job_start  = 0;
    bit stall_res  = 1'b0;
    bit cv_hold    = 1'b0;
    bit prev_done  = 1'b0;

    always #5 clk = ~clk;

    keccak_driver dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_cmd_valid      (cmd_valid),
        .o_cmd_ready      (cmd_ready),
        .i_cmd_mode       (cmd_mode),
        .i_cmd_in_len     (cmd_in_len),
        .i_cmd_out_len    (cmd_out_len),
        .i_msg_valid      (msg_valid),
        .o_msg_ready      (msg_ready),
        .i_msg_data       (msg_data),
        .o_core_valid_n   (core_valid_n),
        .i_core_ready     (core_ready),
        .o_core_data      (core_data),
        .i_core_valid_out (core_valid_out),
        .o_core_ready_n   (core_ready_n),
        .i_core_data_out  (core_data_out),
        .o_res_valid      (res_valid),
        .i_res_ready      (res_ready),
        .o_res_data       (res_data),
        .o_res_last       (res_last),
        .o_busy           (busy),
        .o_done           (done)
    );

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Source/core/sink stimulus, changed on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            msg_valid = (msg_src.size() > 0) && ($urandom_range(9) < 7);
            msg_data  = msg_valid ? msg_src[0] : {$urandom, $urandom};
            core_ready = ($urandom_range(9) < 7);
            if (core_out.size() == 0) cv_hold = 1'b0;
            else if (!cv_hold) cv_hold = ($urandom_range(9) < 6);
            core_valid_out = cv_hold;
            core_data_out  = (core_out.size() > 0) ? core_out[0] : {$urandom, $urandom};
            res_ready = stall_res ? 1'b0 : ($urandom_range(9) < 7);
        end
    end

    // Monitor: samples one time unit before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                prev_done = 1'b0;
            end else begin
                chk1("busy_vs_cmd_ready", busy, ~cmd_ready);
                if (msg_src.size() == 0) chk1("msg_ready_without_msg", msg_ready, 1'b0);
                if (exp_core.size() != 0) begin
                    chk1("res_valid_before_input_done", res_valid, 1'b0);
                    chk1("core_ack_before_input_done", core_ready_n, 1'b1);
                end
                if (!core_valid_n && core_ready) begin
                    core_xfers++;
                    chk1("core_xfer_expected", exp_core.size() > 0, 1'b1);
                    if (exp_core.size() > 0) chk64("core_word", core_data, exp_core.pop_front());
                end
                if (res_valid && res_ready) begin
                    res_xfers++;
                    chk1("res_xfer_expected", exp_res.size() > 0, 1'b1);
                    if (exp_res.size() > 0) begin
                        res_t e;
                        e = exp_res.pop_front();
                        chk64("res_data", res_data, e.d);
                        chk1("res_last", res_last, e.last);
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk1("done_single_cycle", prev_done, 1'b0);
                    chk1("done_while_busy", busy, 1'b1);
                end
                prev_done = done;
                if (msg_valid && msg_ready && msg_src.size() > 0) void'(msg_src.pop_front());
                if (core_valid_out && !core_ready_n && core_out.size() > 0) begin
                    void'(core_out.pop_front());
                    cv_hold = 1'b0;
                end
            end
        end
    end

    task automatic check_reset_outs(input string tag);
        chk1({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk1({tag, "_msg_ready"}, msg_ready, 1'b0);
        chk1({tag, "_core_valid_n"}, core_valid_n, 1'b1);
        chk1({tag, "_core_ready_n"}, core_ready_n, 1'b1);
        chk1({tag, "_res_valid"}, res_valid, 1'b0);
        chk1({tag, "_res_last"}, res_last, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
    endtask

    // Queue expectations for one job and hand the command to the DUT.
    task automatic issue_job(input logic [1:0] mode, input int unsigned in_len,
                             input int unsigned out_len);
        logic [31:0] il, ol;
        logic [63:0] w;
        int iw, ow, cyc;
        il = in_len;
        ol = out_len;
        iw = int'((in_len + 7) / 8);
        ow = int'((out_len + 63) / 64);
        exp_core.push_back({mode, il[29:0], ol});
        for (int i = 0; i < iw; i++) begin
            w = {$urandom, $urandom};
            msg_src.push_back(w);
            exp_core.push_back(w);
        end
        for (int i = 0; i < ow; i++) begin
            w = {$urandom, $urandom};
            core_out.push_back(w);
            exp_res.push_back('{last: (i == ow - 1), d: w});
        end
        core_xfers = 0;
        res_xfers  = 0;
        job_start  = done_cnt;
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_mode    = mode;
        cmd_in_len  = il;
        cmd_out_len = ol;
        cyc = 0;
        forever begin
            #4;
            if (cmd_ready || cyc >= 50) break;
            @(negedge clk);
            cyc++;
        end
        chk1("cmd_accepted", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic finish_job(input int unsigned in_len, input int unsigned out_len);
        int cyc;
        cyc = 0;
        while (done_cnt == job_start && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chkint("done_pulses", done_cnt - job_start, 1);
        chkint("core_xfers", core_xfers, int'((in_len + 7) / 8) + 1);
        chkint("res_xfers", res_xfers, int'((out_len + 63) / 64));
        chkint("exp_core_left", exp_core.size(), 0);
        chkint("exp_res_left", exp_res.size(), 0);
        #4;
        chk1("idle_after_done", cmd_ready, 1'b1);
        chk1("not_busy_after_done", busy, 1'b0);
    endtask

    task automatic run_job(input logic [1:0] mode, input int unsigned in_len,
                           input int unsigned out_len);
        issue_job(mode, in_len, out_len);
        finish_job(in_len, out_len);
    endtask

    initial begin
        logic [63:0] held;
        int cyc;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check_reset_outs("reset");
        rst = 1'b0;

        // Header only, four digest words
        run_job(ModeShake128, 0, 256);
        // Three message words, single digest word
        run_job(ModeSha256, 17, 64);
        // 25 message words with random source/core gaps
        run_job(ModeSha512, 200, 512);
        // Output length rounding
        run_job(ModeShake256, 8, 1);
        run_job(ModeShake256, 8, 65);

        // Sink stall in the drain phase
        stall_res = 1'b1;
        issue_job(ModeShake256, 16, 256);
        cyc = 0;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (res_valid || cyc >= 2000) break;
        end
        chk1("stall_res_valid_seen", res_valid, 1'b1);
        held = res_data;
        repeat (10) begin
            @(negedge clk);
            #4;
            chk1("stall_core_ready_n", core_ready_n, 1'b1);
            chk1("stall_res_valid", res_valid, 1'b1);
            chk64("stall_res_data", res_data, held);
        end
        stall_res = 1'b0;
        finish_job(16, 256);

        // Random jobs
        for (int j = 0; j < 6; j++) begin
            logic [1:0] m;
            int unsigned il, ol;
            m  = 2'($urandom_range(3));
            il = $urandom_range(120);
            ol = $urandom_range(700, 1);
            run_job(m, il, ol);
        end

        // Reset in the middle of the message phase
        issue_job(ModeShake128, 80, 128);
        cyc = 0;
        while (msg_src.size() > 5 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chkint("msg_words_left_at_reset", msg_src.size(), 5);
        #2;
        rst = 1'b1;
        msg_src.delete();
        exp_core.delete();
        core_out.delete();
        exp_res.delete();
        cv_hold = 1'b0;
        #1;
        check_reset_outs("midjob_reset");
        @(negedge clk);
        #4;
        check_reset_outs("midjob_reset_next");
        @(negedge clk);
        #2;
        rst = 1'b0;
        run_job(ModeSha256, 24, 128);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
